// File: rtl/beta_ctl_fsm.sv
// -----------------------------------------------------------------------------
// beta_ctl_fsm
//   Multicycle control unit for the Beta datapath. It sequences each
//   instruction through FETCH -> EXEC (-> MEM) -> FETCH, handshakes with the
//   instruction and data memories, decodes the ALU function and datapath
//   selects, latches prioritised interrupt requests, and traps on illegal
//   opcodes and on data-memory timeouts.
//
// Parameters
//   N_IRQ        number of interrupt lines, bit 0 has the highest priority
//   MEM_TIMEOUT  MEM cycles without dmem_ready before a bus-error trap (1..255)
//   HAS_MULDIV   0 => opcodes 0x22/0x23/0x32/0x33 decode as illegal
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   op                      IR[31:26], valid from EXEC onward
//   z                       rdata1 == 0, sampled in EXEC for BEQ/BNE
//   supervisor              PC[31]; masks interrupts when 1
//   irq                     interrupt request levels
//   imem_ready, dmem_ready  memory completion strobes
//   imem_req, dmem_req      memory request strobes
//   ir_we, pc_we            IR / PC load pulses
//   alufn                   ALU function
//   pcsel                   0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XADR,
//                           5 reset vector, 6 bus-error vector
//   wdsel                   0 PC+4, 1 ALU, 2 memory read data
//   asel, bsel, moe, mwr, ra2sel, wasel, werf   datapath selects / strobes
//   irq_ack                 one-hot pulse on interrupt entry
//   busy                    1 in every state except FETCH
// -----------------------------------------------------------------------------
module beta_ctl_fsm #(
    parameter int N_IRQ       = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter bit HAS_MULDIV  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic             z,
    input  logic             supervisor,
    input  logic [N_IRQ-1:0] irq,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [5:0]       alufn,
    output logic [2:0]       pcsel,
    output logic [1:0]       wdsel,
    output logic             asel,
    output logic             bsel,
    output logic             moe,
    output logic             mwr,
    output logic             ra2sel,
    output logic             wasel,
    output logic             werf,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MK_LD  = 2'd0,
        MK_ST  = 2'd1,
        MK_LDR = 2'd2
    } mem_kind_t;

    typedef enum logic {
        TK_IRQ    = 1'b0,
        TK_BUSERR = 1'b1
    } trap_kind_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;

    localparam logic [5:0] ALUFN_ADD = 6'b010000;

    localparam logic [2:0] PCSEL_INC    = 3'd0;
    localparam logic [2:0] PCSEL_JMP    = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP  = 3'd3;
    localparam logic [2:0] PCSEL_XADR   = 3'd4;
    localparam logic [2:0] PCSEL_RESET  = 3'd5;
    localparam logic [2:0] PCSEL_BUSERR = 3'd6;

    localparam logic [1:0] WDSEL_PC  = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;

    state_t           state_q, state_d;
    mem_kind_t        mem_kind_q, mem_kind_d;
    trap_kind_t       trap_kind_q, trap_kind_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [7:0]       tmo_q, tmo_d;

    // OP/OPC class: 0x20-0x3F, minus the two unassigned codes in each half
    // (low nibble 7 and F) and, without the multiplier/divider, MUL/DIV.
    function automatic logic alu_op_legal(input logic [5:0] o);
        logic legal;
        legal = o[5] && (o[2:0] != 3'b111);
        if (!HAS_MULDIV && (o[3:1] == 3'b001)) begin
            legal = 1'b0;
        end
        return legal;
    endfunction

    // Highest-priority (lowest-index) pending request as a one-hot vector.
    function automatic logic [N_IRQ-1:0] lowest_set(input logic [N_IRQ-1:0] v);
        logic [N_IRQ-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RST;
            mem_kind_q  <= MK_LD;
            trap_kind_q <= TK_IRQ;
            pending_q   <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_kind_q  <= mem_kind_d;
            trap_kind_q <= trap_kind_d;
            pending_q   <= pending_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_kind_d  = mem_kind_q;
        trap_kind_d = trap_kind_q;
        tmo_d       = tmo_q;

        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        alufn    = '0;
        pcsel    = PCSEL_INC;
        wdsel    = WDSEL_PC;
        asel     = 1'b0;
        bsel     = 1'b0;
        moe      = 1'b0;
        mwr      = 1'b0;
        ra2sel   = 1'b0;
        wasel    = 1'b0;
        werf     = 1'b0;
        irq_ack  = '0;
        busy     = (state_q != ST_FETCH);

        case (state_q)
            ST_RST: begin
                pc_we   = 1'b1;
                pcsel   = PCSEL_RESET;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                // Interrupts are taken between instructions only, so the
                // fetch request is withheld while an unmasked one is pending.
                if ((pending_q != '0) && !supervisor) begin
                    trap_kind_d = TK_IRQ;
                    state_d     = ST_TRAP;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (alu_op_legal(op)) begin
                    alufn   = {2'b01, op[3:0]};
                    bsel    = op[4];
                    wdsel   = WDSEL_ALU;
                    werf    = 1'b1;
                    pc_we   = 1'b1;
                    pcsel   = PCSEL_INC;
                    state_d = ST_FETCH;
                end else begin
                    case (op)
                        OP_LD, OP_ST, OP_LDR: begin
                            alufn = ALUFN_ADD;
                            asel  = (op == OP_LDR);
                            bsel  = (op != OP_LDR);
                            if (op == OP_ST) begin
                                mem_kind_d = MK_ST;
                            end else if (op == OP_LDR) begin
                                mem_kind_d = MK_LDR;
                            end else begin
                                mem_kind_d = MK_LD;
                            end
                            tmo_d   = '0;
                            state_d = ST_MEM;
                        end
                        OP_JMP: begin
                            pcsel   = PCSEL_JMP;
                            wdsel   = WDSEL_PC;
                            werf    = 1'b1;
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end
                        OP_BEQ: begin
                            pcsel   = {2'b00, z};
                            wdsel   = WDSEL_PC;
                            werf    = 1'b1;
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end
                        OP_BNE: begin
                            pcsel   = {2'b00, ~z};
                            wdsel   = WDSEL_PC;
                            werf    = 1'b1;
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            // Illegal opcode: save PC+4 in XP and vector.
                            pcsel   = PCSEL_ILLOP;
                            wasel   = 1'b1;
                            wdsel   = WDSEL_PC;
                            werf    = 1'b1;
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
            end

            ST_MEM: begin
                // Address selects are re-derived from the latched access kind
                // so the ALU keeps producing the effective address.
                dmem_req = 1'b1;
                alufn    = ALUFN_ADD;
                asel     = (mem_kind_q == MK_LDR);
                bsel     = (mem_kind_q != MK_LDR);
                if (mem_kind_q == MK_ST) begin
                    mwr    = 1'b1;
                    ra2sel = 1'b1;
                end else begin
                    moe = 1'b1;
                end

                // A ready arriving on the last allowed cycle still completes.
                if (dmem_ready) begin
                    if (mem_kind_q != MK_ST) begin
                        werf  = 1'b1;
                        wdsel = WDSEL_MEM;
                    end
                    pc_we   = 1'b1;
                    pcsel   = PCSEL_INC;
                    tmo_d   = '0;
                    state_d = ST_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d       = '0;
                    trap_kind_d = TK_BUSERR;
                    state_d     = ST_TRAP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ST_TRAP: begin
                wasel = 1'b1;
                wdsel = WDSEL_PC;
                werf  = 1'b1;
                pc_we = 1'b1;
                if (trap_kind_q == TK_BUSERR) begin
                    pcsel = PCSEL_BUSERR;
                end else begin
                    pcsel   = PCSEL_XADR;
                    irq_ack = lowest_set(pending_q);
                end
                state_d = ST_FETCH;
            end

            default: begin
                state_d = ST_RST;
            end
        endcase

        // While reset is asserted every output is forced low at once, which
        // also aborts an in-flight data access without any writeback.
        if (!reset_n) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            alufn    = '0;
            pcsel    = '0;
            wdsel    = '0;
            asel     = 1'b0;
            bsel     = 1'b0;
            moe      = 1'b0;
            mwr      = 1'b0;
            ra2sel   = 1'b0;
            wasel    = 1'b0;
            werf     = 1'b0;
            irq_ack  = '0;
            busy     = 1'b0;
        end

        // A request asserted in the same cycle as its acknowledge stays pending.
        pending_d = (pending_q & ~irq_ack) | irq;
    end

endmodule

// File: tb/tb_beta_ctl_fsm.sv
module tb_beta_ctl_fsm;

    localparam int N_IRQ       = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam bit HAS_MULDIV  = 1'b1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [5:0]       op = '0;
    logic             z = 1'b0;
    logic             supervisor = 1'b0;
    logic [N_IRQ-1:0] irq = '0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, dmem_req, ir_we, pc_we;
    logic [5:0]       alufn;
    logic [2:0]       pcsel;
    logic [1:0]       wdsel;
    logic             asel, bsel, moe, mwr, ra2sel, wasel, werf;
    logic [N_IRQ-1:0] irq_ack;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_we;
        logic       pc_we;
        logic [5:0] alufn;
        logic [2:0] pcsel;
        logic [1:0] wdsel;
        logic       asel;
        logic       bsel;
        logic       moe;
        logic       mwr;
        logic       ra2sel;
        logic       wasel;
        logic       werf;
        logic [3:0] irq_ack;
        logic       busy;
    } ctl_t;

    always #5 clk = ~clk;

    beta_ctl_fsm #(
        .N_IRQ      (N_IRQ),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .HAS_MULDIV (HAS_MULDIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .z         (z),
        .supervisor(supervisor),
        .irq       (irq),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .alufn     (alufn),
        .pcsel     (pcsel),
        .wdsel     (wdsel),
        .asel      (asel),
        .bsel      (bsel),
        .moe       (moe),
        .mwr       (mwr),
        .ra2sel    (ra2sel),
        .wasel     (wasel),
        .werf      (werf),
        .irq_ack   (irq_ack),
        .busy      (busy)
    );

    function automatic ctl_t cur();
        return {imem_req, dmem_req, ir_we, pc_we, alufn, pcsel, wdsel,
                asel, bsel, moe, mwr, ra2sel, wasel, werf, irq_ack, busy};
    endfunction

    // Strobes are always significant; selects only where they have effect.
    function automatic ctl_t care(input ctl_t e, input logic dp, input logic mm);
        ctl_t m;
        m          = '0;
        m.imem_req = 1'b1;
        m.dmem_req = 1'b1;
        m.ir_we    = 1'b1;
        m.pc_we    = 1'b1;
        m.mwr      = 1'b1;
        m.werf     = 1'b1;
        m.irq_ack  = '1;
        m.busy     = 1'b1;
        if (e.pc_we) m.pcsel = '1;
        if (e.werf) begin
            m.wdsel = '1;
            m.wasel = 1'b1;
        end
        if (dp) begin
            m.alufn = '1;
            m.asel  = 1'b1;
            m.bsel  = 1'b1;
        end
        if (mm) begin
            m.moe    = 1'b1;
            m.ra2sel = 1'b1;
        end
        return m;
    endfunction

    // Instruction-class reference for the EXEC cycle, built from opcode ranges.
    function automatic void model_exec(input logic [5:0] o, input logic zz,
                                       output ctl_t e, output logic to_mem,
                                       output logic dp);
        int v;
        int lo;
        v      = int'(o);
        lo     = v % 16;
        e      = '0;
        e.busy = 1'b1;
        to_mem = 1'b0;
        dp     = 1'b0;
        if (v >= 32 && lo != 7 && lo != 15 && (HAS_MULDIV || (lo != 2 && lo != 3))) begin
            e.alufn = 6'(16 + lo);
            e.bsel  = (v >= 48);
            e.wdsel = 2'd1;
            e.werf  = 1'b1;
            e.pc_we = 1'b1;
            dp      = 1'b1;
        end else if (v == 24 || v == 25 || v == 31) begin
            e.alufn = 6'd16;
            e.asel  = (v == 31);
            e.bsel  = (v != 31);
            to_mem  = 1'b1;
            dp      = 1'b1;
        end else if (v == 27 || v == 28 || v == 29) begin
            if (v == 27)      e.pcsel = 3'd2;
            else if (v == 28) e.pcsel = zz ? 3'd1 : 3'd0;
            else              e.pcsel = zz ? 3'd0 : 3'd1;
            e.werf  = 1'b1;
            e.pc_we = 1'b1;
        end else begin
            e.pcsel = 3'd3;
            e.wasel = 1'b1;
            e.werf  = 1'b1;
            e.pc_we = 1'b1;
        end
    endfunction

    task automatic test_reset();
        ctl_t e, m;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        e = '0;
        vectors++;
        if (cur() !== e) begin
            miscompares++;
            $display("FAIL reset_assert: got %h want %h", cur(), e);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (cur() !== e) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", cur(), e);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        e = '0; e.pc_we = 1'b1; e.pcsel = 3'd5; e.busy = 1'b1;
        m = care(e, 1'b0, 1'b0);
        vectors++;
        if ((cur() & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL reset_rst_cycle: got %h want %h", cur(), e);
        end
        @(negedge clk);
        #1;
        e = '0; e.imem_req = 1'b1;
        m = care(e, 1'b0, 1'b0);
        vectors++;
        if ((cur() & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL reset_first_fetch: got %h want %h", cur(), e);
        end
        @(negedge clk);
    endtask

    task automatic test_exec_decode();
        logic [5:0] ops[$];
        ctl_t       e, m;
        logic       to_mem, dp, zz;
        ops = '{6'h30, 6'h22, 6'h3F, 6'h27, 6'h20, 6'h01, 6'h1B, 6'h1C,
                6'h1C, 6'h1D, 6'h1D, 6'h00};
        repeat (40) ops.push_back(6'($urandom_range(0, 63)));
        foreach (ops[i]) begin
            if (ops[i] == 6'h18 || ops[i] == 6'h19 || ops[i] == 6'h1F) continue;
            zz = (i < 12) ? i[0] : 1'($urandom_range(0, 1));
            op = ops[i];
            z  = zz;
            imem_ready = 1'b1;
            #1;
            e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
            m = care(e, 1'b0, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL fetch_op%02h: got %h want %h", ops[i], cur(), e);
            end
            @(negedge clk);
            imem_ready = 1'b0;
            #1;
            model_exec(ops[i], zz, e, to_mem, dp);
            m = care(e, dp, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL exec_op%02h_z%0d: got %h want %h", ops[i], zz, cur(), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_access();
        logic [5:0] kinds[3];
        logic [5:0] o;
        int         lat;
        logic       ld, to_mem, dp;
        ctl_t       e, m;
        kinds = '{6'h18, 6'h19, 6'h1F};
        for (int t = 0; t < 13; t++) begin
            o   = (t == 0) ? 6'h18 : kinds[$urandom_range(0, 2)];
            lat = (t == 0) ? 4 : (t == 1) ? MEM_TIMEOUT - 1 : $urandom_range(0, MEM_TIMEOUT - 1);
            ld  = (o != 6'h19);
            op = o;
            imem_ready = 1'b1;
            #1;
            @(negedge clk);
            imem_ready = 1'b0;
            #1;
            model_exec(o, z, e, to_mem, dp);
            m = care(e, dp, 1'b0);
            if (o == 6'h1F) m.bsel = 1'b0;
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL mem_exec_op%02h: got %h want %h", o, cur(), e);
            end
            @(negedge clk);
            for (int k = 0; k <= lat; k++) begin
                dmem_ready = (k == lat);
                #1;
                e = '0; e.dmem_req = 1'b1; e.busy = 1'b1; e.alufn = 6'b010000;
                e.asel = (o == 6'h1F); e.bsel = (o != 6'h1F);
                e.moe = ld; e.mwr = !ld; e.ra2sel = !ld;
                if (k == lat) begin
                    e.pc_we = 1'b1;
                    e.werf  = ld;
                    e.wdsel = ld ? 2'd2 : 2'd0;
                end
                m = care(e, 1'b1, 1'b1);
                if (o == 6'h1F) m.bsel = 1'b0;
                vectors++;
                if ((cur() & m) !== (e & m)) begin
                    miscompares++;
                    $display("FAIL mem_op%02h_lat%0d_cyc%0d: got %h want %h", o, lat, k, cur(), e);
                end
                @(negedge clk);
            end
            dmem_ready = 1'b0;
            #1;
            e = '0; e.imem_req = 1'b1;
            m = care(e, 1'b0, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL mem_return_fetch_op%02h: got %h want %h", o, cur(), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_timeout();
        logic [5:0] o;
        logic       ld;
        ctl_t       e, m;
        for (int t = 0; t < 2; t++) begin
            o  = (t == 0) ? 6'h19 : 6'h18;
            ld = (o != 6'h19);
            op = o;
            imem_ready = 1'b1;
            #1;
            @(negedge clk);
            imem_ready = 1'b0;
            #1;
            @(negedge clk);
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                dmem_ready = 1'b0;
                #1;
                e = '0; e.dmem_req = 1'b1; e.busy = 1'b1; e.alufn = 6'b010000;
                e.bsel = 1'b1; e.moe = ld; e.mwr = !ld; e.ra2sel = !ld;
                m = care(e, 1'b1, 1'b1);
                vectors++;
                if ((cur() & m) !== (e & m)) begin
                    miscompares++;
                    $display("FAIL tmo_wait_op%02h_cyc%0d: got %h want %h", o, k, cur(), e);
                end
                @(negedge clk);
            end
            dmem_ready = (t == 1);
            #1;
            e = '0; e.wasel = 1'b1; e.werf = 1'b1; e.pc_we = 1'b1; e.pcsel = 3'd6; e.busy = 1'b1;
            m = care(e, 1'b0, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL tmo_trap_op%02h: got %h want %h", o, cur(), e);
            end
            @(negedge clk);
            dmem_ready = 1'b0;
            #1;
            e = '0; e.imem_req = 1'b1;
            m = care(e, 1'b0, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL tmo_return_fetch_op%02h: got %h want %h", o, cur(), e);
            end
            @(negedge clk);
        end
    endtask

    // Each row: supervisor, irq driven, expected kind (0 fetch, 1 fetch
    // withheld, 2 interrupt trap), expected irq_ack.
    task automatic test_irq_directed();
        logic       sup_t[17];
        logic [3:0] irq_t[17];
        int         kind_t[17];
        logic [3:0] ack_t[17];
        ctl_t       e, m;
        sup_t  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        irq_t  = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                   4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                   4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        kind_t = '{0, 1, 2, 1, 2, 0, 0, 1, 2, 1, 2, 0, 0, 0, 1, 2, 0};
        ack_t  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                   4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        imem_ready = 1'b0;
        for (int r = 0; r < 17; r++) begin
            supervisor = sup_t[r];
            irq        = irq_t[r];
            #1;
            e = '0;
            if (kind_t[r] == 0) begin
                e.imem_req = 1'b1;
            end else if (kind_t[r] == 2) begin
                e.wasel = 1'b1; e.werf = 1'b1; e.pc_we = 1'b1; e.pcsel = 3'd4;
                e.irq_ack = ack_t[r]; e.busy = 1'b1;
            end
            m = care(e, 1'b0, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL irq_dir_row%0d: got %h want %h", r, cur(), e);
            end
            @(negedge clk);
        end
        irq = '0;
        supervisor = 1'b0;
    endtask

    task automatic test_irq_random();
        logic [3:0] pend;
        logic [3:0] ack;
        logic [3:0] drv;
        logic       in_trap;
        ctl_t       e, m;
        pend       = '0;
        in_trap    = 1'b0;
        imem_ready = 1'b0;
        for (int k = 0; k < 80; k++) begin
            drv = (k < 60 && $urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            supervisor = (k < 60) && ($urandom_range(0, 3) == 0);
            irq = drv;
            #1;
            e = '0;
            if (in_trap) begin
                ack = pend & (~pend + 4'd1);
                e.wasel = 1'b1; e.werf = 1'b1; e.pc_we = 1'b1; e.pcsel = 3'd4;
                e.irq_ack = ack; e.busy = 1'b1;
                pend    = pend & ~ack;
                in_trap = 1'b0;
            end else if (pend != 4'b0000 && !supervisor) begin
                in_trap = 1'b1;
            end else begin
                e.imem_req = 1'b1;
            end
            pend = pend | drv;
            m = care(e, 1'b0, 1'b0);
            vectors++;
            if ((cur() & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL irq_rand_cyc%0d: got %h want %h", k, cur(), e);
            end
            @(negedge clk);
        end
        irq = '0;
        supervisor = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        ctl_t e, m;
        op = 6'h19;
        imem_ready = 1'b1;
        #1;
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        @(negedge clk);
        irq = 4'b1000;
        #1;
        e = '0; e.dmem_req = 1'b1; e.mwr = 1'b1; e.busy = 1'b1;
        m = care(e, 1'b0, 1'b0);
        vectors++;
        if ((cur() & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL midmem_store_active: got %h want %h", cur(), e);
        end
        @(negedge clk);
        irq = '0;
        #3;
        reset_n = 1'b0;
        #1;
        e = '0;
        vectors++;
        if (cur() !== e) begin
            miscompares++;
            $display("FAIL midmem_async_abort: got %h want %h", cur(), e);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        e = '0; e.pc_we = 1'b1; e.pcsel = 3'd5; e.busy = 1'b1;
        m = care(e, 1'b0, 1'b0);
        vectors++;
        if ((cur() & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL midmem_rst_cycle: got %h want %h", cur(), e);
        end
        @(negedge clk);
        #1;
        e = '0; e.imem_req = 1'b1;
        m = care(e, 1'b0, 1'b0);
        vectors++;
        if ((cur() & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL midmem_pending_cleared: got %h want %h", cur(), e);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_exec_decode();
        test_mem_access();
        test_mem_timeout();
        test_irq_directed();
        test_irq_random();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
